// File: rtl/boxcar_pkg.sv
// boxcar_pkg: shared FSM state, result tag and packed-sample slicing for the boxcar scheduler
package boxcar_pkg;

    localparam int TAG_CH_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_CH_W-1:0] ch;
        logic                warm;
    } tag_t;

    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/boxcar_scheduler_rr_arbiter.sv
// rr_arbiter: cyclic one-hot grant starting at a registered pointer that moves past each winner
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_grant
);

    localparam int PW = $clog2(NUM_CH);

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the first requester at or after ptr wins.
    always_comb begin
        o_grant = '0;
        idx = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            idx = PW'((int'(ptr) + j) % NUM_CH);
            if (i_req[idx]) begin
                o_grant = '0;
                o_grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            ptr <= '0;
        else if (i_advance)
            for (int k = 0; k < NUM_CH; k++)
                if (o_grant[k])
                    ptr <= PW'((k + 1) % NUM_CH);
    end

endmodule

// File: rtl/boxcar_scheduler.sv
// boxcar_scheduler: round-robin sharing of one boxcar filter engine with warm-up tagging of results
module boxcar_scheduler
    import boxcar_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SAMPLES = 2,
    parameter int FLT_LATENCY = 1,
    parameter int CH_WIDTH    = $clog2(NUM_CH),
    parameter int CNT_WIDTH   = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_enable,
    input  logic [NUM_CH-1:0]            i_ch_clear,
    input  logic [NUM_CH-1:0]            i_req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_CH-1:0]            o_req_ready,
    output logic                         o_flt_ce,
    output logic [DATA_WIDTH-1:0]        o_flt_data,
    output logic [CH_WIDTH-1:0]          o_flt_ch,
    output logic                         o_out_valid,
    output logic [CH_WIDTH-1:0]          o_out_ch,
    output logic                         o_out_warm,
    output logic                         o_busy
);

    state_e                state;
    tag_t                  pipe [FLT_LATENCY+1];
    logic [CNT_WIDTH-1:0]  cnt  [NUM_CH];
    logic [NUM_CH-1:0]     grant;
    logic                  run;
    logic                  xfer;
    logic                  issue_warm;
    logic                  in_flight;
    logic [CH_WIDTH-1:0]   issue_ch;
    logic [DATA_WIDTH-1:0] issue_data;

    assign run  = state == RUN;
    assign xfer = |grant;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (i_req_valid & {NUM_CH{run}}),
        .i_advance (run),
        .o_grant   (grant)
    );

    // A clear coinciding with the transfer makes this issue count as the first sample.
    always_comb begin
        issue_ch   = '0;
        issue_data = '0;
        issue_warm = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (grant[k]) begin
                issue_ch   = CH_WIDTH'(k);
                issue_data = i_req_data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
                issue_warm = i_ch_clear[k] ? (NUM_SAMPLES <= 1) : (int'(cnt[k]) + 1 >= NUM_SAMPLES);
            end
    end

    // The last stage is already presenting its result, so it does not hold off IDLE.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < FLT_LATENCY; i++)
            in_flight = in_flight | pipe[i].valid;
    end

    always_ff @(posedge i_clk) begin
        state <= !i_reset_n ? IDLE :
                 i_enable ? RUN :
                 (run || (state == DRAIN && in_flight)) ? DRAIN : IDLE;
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_CH; k++)
            if (!i_reset_n)
                cnt[k] <= '0;
            else if (i_ch_clear[k])
                cnt[k] <= CNT_WIDTH'(grant[k]);
            else if (grant[k] && int'(cnt[k]) < NUM_SAMPLES)
                cnt[k] <= cnt[k] + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i <= FLT_LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: xfer, ch: TAG_CH_W'(issue_ch), warm: issue_warm};
            for (int i = 1; i <= FLT_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        o_flt_data <= !i_reset_n ? '0 : xfer ? issue_data : o_flt_data;
    end

    assign o_req_ready = grant;
    assign o_flt_ce    = pipe[0].valid;
    assign o_flt_ch    = pipe[0].ch[CH_WIDTH-1:0];
    assign o_out_valid = pipe[FLT_LATENCY].valid;
    assign o_out_ch    = pipe[FLT_LATENCY].ch[CH_WIDTH-1:0];
    assign o_out_warm  = pipe[FLT_LATENCY].warm;
    assign o_busy      = state != IDLE;

endmodule

// File: tb/tb_boxcar_scheduler.sv
// tb_boxcar_scheduler: randomized and directed stimulus against a queue-based reference model and scoreboard
module tb_boxcar_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NS = 2;
    localparam int L  = 3;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [N-1:0]      clr = '0;
    logic [N-1:0]      vld = '0;
    logic [N*DW-1:0]   data = '0;
    logic [N-1:0]      o_req_ready;
    logic              o_flt_ce;
    logic [DW-1:0]     o_flt_data;
    logic [CW-1:0]     o_flt_ch;
    logic              o_out_valid;
    logic [CW-1:0]     o_out_ch;
    logic              o_out_warm;
    logic              o_busy;

    boxcar_scheduler #(
        .NUM_CH(N), .DATA_WIDTH(DW), .NUM_SAMPLES(NS), .FLT_LATENCY(L)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_enable    (en),
        .i_ch_clear  (clr),
        .i_req_valid (vld),
        .i_req_data  (data),
        .o_req_ready (o_req_ready),
        .o_flt_ce    (o_flt_ce),
        .o_flt_data  (o_flt_data),
        .o_flt_ch    (o_flt_ch),
        .o_out_valid (o_out_valid),
        .o_out_ch    (o_out_ch),
        .o_out_warm  (o_out_warm),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int stamp;
        int ch;
        int val;
    } exp_t;

    exp_t iq[$];
    exp_t rq[$];
    exp_t me;
    int checks = 0;
    int errors = 0;

    // Reference model: spec-level view of the scheduler.
    int ptr = 0;
    int cnt[N];
    bit run_m = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit e, input logic [N-1:0] v, input logic [N-1:0] c,
                        input bit r, input logic [N*DW-1:0] d, output int g);
        bit w;
        @(posedge clk);
        #1;
        en = e; vld = v; clr = c; data = d; rst_n = ~r;
        #1;
        g = -1;
        if (run_m)
            for (int j = 0; j < N; j++)
                if (g < 0 && v[(ptr + j) % N]) g = (ptr + j) % N;
        chk("ready", int'(o_req_ready), g < 0 ? 0 : (1 << g));
        if (r) begin
            g = -1;
            ptr = 0;
            run_m = 1'b0;
            for (int k = 0; k < N; k++) cnt[k] = 0;
            while (iq.size() > 0 && iq[$].stamp > cyc) void'(iq.pop_back());
            while (rq.size() > 0 && rq[$].stamp > cyc) void'(rq.pop_back());
        end else begin
            if (g >= 0) begin
                w = ((c[g] ? 0 : cnt[g]) + 1) >= NS;
                iq.push_back('{cyc + 1, g, int'(d[g*DW +: DW])});
                rq.push_back('{cyc + 1 + L, g, int'(w)});
                ptr = (g + 1) % N;
            end
            for (int k = 0; k < N; k++)
                if (c[k]) cnt[k] = (g == k) ? 1 : 0;
                else if (g == k && cnt[k] < NS) cnt[k]++;
            run_m = e;
        end
    endtask

    task automatic do_reset();
        int g;
        step(1'b0, '0, '0, 1'b1, '0, g);
        step(1'b0, '0, '0, 1'b1, '0, g);
        chk("rst_ready", int'(o_req_ready), 0);
        chk("rst_flt_ce", int'(o_flt_ce), 0);
        chk("rst_flt_data", int'(o_flt_data), 0);
        chk("rst_flt_ch", int'(o_flt_ch), 0);
        chk("rst_out_valid", int'(o_out_valid), 0);
        chk("rst_out_ch", int'(o_out_ch), 0);
        chk("rst_out_warm", int'(o_out_warm), 0);
        chk("rst_busy", int'(o_busy), 0);
    endtask

    // Scoreboard monitor: pops on every DUT strobe or on any expectation that is due.
    initial forever begin
        @(negedge clk);
        if (o_flt_ce || (iq.size() > 0 && iq[0].stamp <= cyc)) begin
            if (iq.size() == 0) chk("flt_ce_unexpected", 1, 0);
            else begin
                me = iq.pop_front();
                chk("flt_ce_cycle", o_flt_ce ? cyc : -1, me.stamp);
                if (o_flt_ce) begin
                    chk("flt_ch", int'(o_flt_ch), me.ch);
                    chk("flt_data", int'(o_flt_data), me.val);
                end
            end
        end
        if (o_out_valid || (rq.size() > 0 && rq[0].stamp <= cyc)) begin
            if (rq.size() == 0) chk("out_valid_unexpected", 1, 0);
            else begin
                me = rq.pop_front();
                chk("out_valid_cycle", o_out_valid ? cyc : -1, me.stamp);
                if (o_out_valid) begin
                    chk("out_ch", int'(o_out_ch), me.ch);
                    chk("out_warm", int'(o_out_warm), me.val);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g, n, t, since, guard;
        logic [N*DW-1:0] dd;
        logic [7:0] d2 [3];
        d2[0] = 8'h11; d2[1] = 8'h22; d2[2] = 8'h33;
        for (int k = 0; k < N; k++) cnt[k] = 0;

        // Single channel 2 stream: warm sequence 0,1,1.
        do_reset();
        n = 0;
        guard = 0;
        while (n < 3 && guard < 20) begin
            dd = '0;
            dd[2*DW +: DW] = d2[n];
            step(1'b1, 4'b0100, '0, 1'b0, dd, g);
            if (g == 2) n++;
            guard++;
        end
        chk("ch2_grants", n, 3);
        for (int i = 0; i < L + 2; i++) step(1'b1, '0, '0, 1'b0, '0, g);

        // All channels valid: strict rotation from ch0.
        do_reset();
        step(1'b1, '0, '0, 1'b0, '0, g);
        for (int i = 0; i < 8; i++) begin
            dd = $urandom;
            step(1'b1, 4'b1111, '0, 1'b0, dd, g);
            chk("rr_order", g, i % N);
        end

        // Channel 1 clear coinciding with a transfer.
        for (int i = 0; i < 5; i++) begin
            dd = $urandom;
            step(1'b1, 4'b0010, (i == 2) ? 4'b0010 : 4'b0000, 1'b0, dd, g);
            chk("ch1_grant", g, 1);
        end

        // Enable dropped in the cycle of a transfer, then drain.
        step(1'b0, 4'b0001, '0, 1'b0, 32'h0000_00A5, g);
        chk("drop_grant", g, 0);
        t = cyc;
        for (int i = 0; i < L + 4; i++) begin
            step(1'b0, 4'b0001, '0, 1'b0, 32'h0000_005A, g);
            if (cyc == t + 1 + L) chk("drain_busy_hi", int'(o_busy), 1);
            if (cyc == t + 2 + L) chk("drain_busy_lo", int'(o_busy), 0);
        end

        // Reset one cycle after a grant drops the in-flight result.
        do_reset();
        step(1'b1, '0, '0, 1'b0, '0, g);
        step(1'b1, 4'b0100, '0, 1'b0, 32'h00C3_0000, g);
        chk("pre_reset_grant", g, 2);
        step(1'b1, 4'b0100, '0, 1'b1, 32'h00C3_0000, g);
        do_reset();
        step(1'b1, '0, '0, 1'b0, '0, g);
        step(1'b1, 4'b1111, '0, 1'b0, 32'h4433_2211, g);
        chk("first_after_reset", g, 0);

        // ch3 held valid while ch0 toggles: ch3 never waits more than N cycles.
        since = 0;
        for (int i = 0; i < 24; i++) begin
            dd = $urandom;
            step(1'b1, {1'b1, 2'b00, 1'(i % 2)}, '0, 1'b0, dd, g);
            since = (g == 3) ? 0 : since + 1;
            chk("ch3_starve", int'(since >= N), 0);
        end

        // Randomized traffic with occasional clears, enable drops and resets.
        for (int i = 0; i < 600; i++) begin
            dd = $urandom;
            step($urandom_range(0, 15) != 0, 4'($urandom),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
                 $urandom_range(0, 99) == 0, dd, g);
        end

        for (int i = 0; i < L + 4; i++) step(1'b0, '0, '0, 1'b0, '0, g);
        chk("issue_queue_empty", iq.size(), 0);
        chk("result_queue_empty", rq.size(), 0);
        chk("final_busy", int'(o_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
